// File: rtl/ls_exec_unit.sv
// Load/store execution unit: in-order issue queue feeding a single-outstanding
// memory handshake, with load results on the CDB and store completions on st_done.
module ls_exec_unit #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [3:0]        opcode_in,
  input  logic [DATA_W-1:0] opr1_in,
  input  logic [DATA_W-1:0] opr2_in,
  input  logic [TAG_W-1:0]  rrf_dest_in,
  input  logic              valid_in,
  output logic              lsq_full,
  output logic              lsq_overflow,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output logic              st_done,
  output logic [DATA_W-1:0] st_pc
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StReq, StWb} state_e;

  logic [DATA_W-1:0] q_pc    [DEPTH];
  logic [DATA_W-1:0] q_addr  [DEPTH];
  logic [DATA_W-1:0] q_wdata [DEPTH];
  logic [TAG_W-1:0]  q_tag   [DEPTH];
  logic              q_we    [DEPTH];

  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q, count_d;
  state_e            state_q;

  logic              is_ls;
  logic              pop;
  logic              push;
  logic              drop;
  logic [DATA_W-1:0] enq_addr;

  assign is_ls    = (opcode_in[3:1] == 3'b100);
  assign lsq_full = (count_q == CNT_W'(DEPTH));
  assign pop      = (state_q == StReq) && mem_ready;
  // A pop in the same cycle frees the slot, so a full queue can still accept.
  assign push     = valid_in && is_ls && (!lsq_full || pop);
  assign drop     = valid_in && is_ls && lsq_full && !pop;
  assign enq_addr = opcode_in[0] ? opr2_in : (opr1_in + opr2_in);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail_q]    <= pc_in;
      q_we[tail_q]    <= opcode_in[0];
      q_addr[tail_q]  <= enq_addr;
      q_wdata[tail_q] <= opr1_in;
      q_tag[tail_q]   <= rrf_dest_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      lsq_overflow <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) begin
        tail_q <= tail_q + 1'b1;
      end
      if (pop) begin
        head_q <= head_q + 1'b1;
      end
      if (drop) begin
        lsq_overflow <= 1'b1;
      end
    end
  end

  // Outputs are registered alongside the state so each state owns its values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      st_done   <= 1'b0;
      st_pc     <= '0;
    end else begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      st_done   <= 1'b0;
      st_pc     <= '0;
      case (state_q)
        StIdle: begin
          if (count_q != '0) begin
            state_q   <= StReq;
            mem_req   <= 1'b1;
            mem_we    <= q_we[head_q];
            mem_addr  <= q_addr[head_q];
            mem_wdata <= q_wdata[head_q];
          end
        end
        StReq: begin
          if (mem_ready) begin
            state_q   <= StWb;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if (q_we[head_q]) begin
              st_done <= 1'b1;
              st_pc   <= q_pc[head_q];
            end else begin
              cdb_valid <= 1'b1;
              cdb_tag   <= q_tag[head_q];
              cdb_data  <= mem_rdata;
            end
          end
        end
        StWb: begin
          // Head has already advanced past the completed op.
          if (count_q != '0) begin
            state_q   <= StReq;
            mem_req   <= 1'b1;
            mem_we    <= q_we[head_q];
            mem_addr  <= q_addr[head_q];
            mem_wdata <= q_wdata[head_q];
          end else begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
